// File: rtl/status_register_pkg.sv
// Shared types for the 6502 status register: flag_op encoding, P bit indices, stored-flag struct.
package status_register_pkg;

  localparam int unsigned FLAG_OP_W = 4;
  localparam int unsigned P_W       = 8;

  localparam int unsigned P_C = 0;
  localparam int unsigned P_Z = 1;
  localparam int unsigned P_I = 2;
  localparam int unsigned P_D = 3;
  localparam int unsigned P_B = 4;
  localparam int unsigned P_U = 5;
  localparam int unsigned P_V = 6;
  localparam int unsigned P_N = 7;

  typedef enum logic [FLAG_OP_W-1:0] {
    NOP      = 4'd0,
    ALU_NZ   = 4'd1,
    ALU_NZC  = 4'd2,
    ALU_NVZC = 4'd3,
    BIT      = 4'd4,
    LOAD_BUS = 4'd5,
    SEC      = 4'd6,
    CLC      = 4'd7,
    SEI      = 4'd8,
    CLI      = 4'd9,
    SED      = 4'd10,
    CLD      = 4'd11,
    CLV      = 4'd12
  } flag_op_t;

  // Only the six architectural flags are stored; bit5 and B are synthesised on read.
  typedef struct packed {
    logic n;
    logic v;
    logic d;
    logic i;
    logic z;
    logic c;
  } flags_t;

  function automatic logic [P_W-1:0] p_image(flags_t f, logic b);
    logic [P_W-1:0] img;
    img      = '0;
    img[P_N] = f.n;
    img[P_V] = f.v;
    img[P_U] = 1'b1;
    img[P_B] = b;
    img[P_D] = f.d;
    img[P_I] = f.i;
    img[P_Z] = f.z;
    img[P_C] = f.c;
    return img;
  endfunction

endpackage

// File: rtl/status_register_if.sv
// Control/ALU/bus/interrupt connection bundle for status_register.
interface status_register_if;
  import status_register_pkg::*;

  flag_op_t       flag_op;
  logic           alu_negative;
  logic           alu_overflow;
  logic           alu_zero;
  logic           alu_carry;
  logic [P_W-1:0] data_in;
  logic           push_brk;
  logic [P_W-1:0] p_out;
  logic [P_W-1:0] p_push;
  logic           carry_flag;
  logic           decimal_flag;
  logic           irq_n;
  logic           nmi_n;
  logic           nmi_ack;
  logic           irq_pending;
  logic           nmi_pending;

  modport master (
    output flag_op, alu_negative, alu_overflow, alu_zero, alu_carry,
    output data_in, push_brk, irq_n, nmi_n, nmi_ack,
    input  p_out, p_push, carry_flag, decimal_flag, irq_pending, nmi_pending
  );

  modport slave (
    input  flag_op, alu_negative, alu_overflow, alu_zero, alu_carry,
    input  data_in, push_brk, irq_n, nmi_n, nmi_ack,
    output p_out, p_push, carry_flag, decimal_flag, irq_pending, nmi_pending
  );
endinterface

// File: rtl/status_register_sync_n.sv
// Multi-flop synchroniser for an asynchronous active-low pin; resets to the idle (1) level.
module sync_n #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_n_i,
  output logic sync_n_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_n_i};
    end
  end

  assign sync_n_o = sync_q[STAGES-1];

endmodule

// File: rtl/status_register.sv
// 6502 P register with flag update ops, push image and IRQ/NMI request front end.
// Build option DECIMAL_MODE_EN: when defined, decimal_flag follows stored D; otherwise tied 0.
module status_register
  import status_register_pkg::*;
#(
  parameter logic [P_W-1:0] RESET_VALUE = 8'h24,
  parameter int unsigned    SYNC_STAGES = 2
) (
  input logic               clk,
  input logic               rst_n,
  status_register_if.slave  sr_if
);

  flags_t flags_q, flags_d;
  logic   irq_sync, nmi_sync;
  logic   nmi_prev_q;
  logic   nmi_pending_q, nmi_pending_d;
  logic   nmi_fall_c;
  logic   unused_bits;

  sync_n #(.STAGES(SYNC_STAGES)) u_irq_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .async_n_i (sr_if.irq_n),
    .sync_n_o  (irq_sync)
  );

  sync_n #(.STAGES(SYNC_STAGES)) u_nmi_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .async_n_i (sr_if.nmi_n),
    .sync_n_o  (nmi_sync)
  );

  // Flag next-state: each op touches only the flags it names.
  always_comb begin
    flags_d = flags_q;
    case (sr_if.flag_op)
      ALU_NZ: begin
        flags_d.n = sr_if.alu_negative;
        flags_d.z = sr_if.alu_zero;
      end
      ALU_NZC: begin
        flags_d.n = sr_if.alu_negative;
        flags_d.z = sr_if.alu_zero;
        flags_d.c = sr_if.alu_carry;
      end
      ALU_NVZC: begin
        flags_d.n = sr_if.alu_negative;
        flags_d.v = sr_if.alu_overflow;
        flags_d.z = sr_if.alu_zero;
        flags_d.c = sr_if.alu_carry;
      end
      BIT: begin
        flags_d.n = sr_if.data_in[P_N];
        flags_d.v = sr_if.data_in[P_V];
        flags_d.z = sr_if.alu_zero;
      end
      LOAD_BUS: begin
        flags_d.n = sr_if.data_in[P_N];
        flags_d.v = sr_if.data_in[P_V];
        flags_d.d = sr_if.data_in[P_D];
        flags_d.i = sr_if.data_in[P_I];
        flags_d.z = sr_if.data_in[P_Z];
        flags_d.c = sr_if.data_in[P_C];
      end
      SEC:     flags_d.c = 1'b1;
      CLC:     flags_d.c = 1'b0;
      SEI:     flags_d.i = 1'b1;
      CLI:     flags_d.i = 1'b0;
      SED:     flags_d.d = 1'b1;
      CLD:     flags_d.d = 1'b0;
      CLV:     flags_d.v = 1'b0;
      default: ;
    endcase
  end

  // A new falling edge beats a same-cycle ack so no NMI is lost.
  assign nmi_fall_c    = nmi_prev_q & ~nmi_sync;
  assign nmi_pending_d = nmi_fall_c | (nmi_pending_q & ~sr_if.nmi_ack);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q       <= '{n: RESET_VALUE[P_N], v: RESET_VALUE[P_V], d: RESET_VALUE[P_D],
                         i: RESET_VALUE[P_I], z: RESET_VALUE[P_Z], c: RESET_VALUE[P_C]};
      nmi_prev_q    <= 1'b1;
      nmi_pending_q <= 1'b0;
    end else begin
      flags_q       <= flags_d;
      nmi_prev_q    <= nmi_sync;
      nmi_pending_q <= nmi_pending_d;
    end
  end

  assign sr_if.p_out       = p_image(flags_q, 1'b1);
  assign sr_if.p_push      = p_image(flags_q, sr_if.push_brk);
  assign sr_if.carry_flag  = flags_q.c;
  assign sr_if.nmi_pending = nmi_pending_q;
  // Masked by the registered I, so SEI/CLI/PLP take effect one cycle late.
  assign sr_if.irq_pending = ~irq_sync & ~flags_q.i;

`ifdef DECIMAL_MODE_EN
  assign sr_if.decimal_flag = flags_q.d;
`else
  assign sr_if.decimal_flag = 1'b0;
`endif

  // Bus bits 5 and 4 carry no stored state.
  assign unused_bits = ^sr_if.data_in[P_U:P_B];

endmodule

// File: tb/tb_status_register.sv
// Self-checking bench for status_register: per-cycle reference model plus directed literal checks.
module tb_status_register;
  import status_register_pkg::*;

  localparam int unsigned SYNC = 2;
`ifdef DECIMAL_MODE_EN
  localparam logic DEC_EXP = 1'b1;
`else
  localparam logic DEC_EXP = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  status_register_if sr();

  status_register #(.RESET_VALUE(8'h24), .SYNC_STAGES(SYNC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sr_if (sr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: P as a byte with bits 5,4 reading 1; pins tracked as sample histories.
  logic [7:0]    m_p;
  logic [SYNC:0] irq_h, nmi_h;
  logic          m_nmi;

  function automatic logic [7:0] next_p(input logic [7:0] p, input flag_op_t op,
                                        input logic n, input logic v, input logic z,
                                        input logic c, input logic [7:0] d);
    logic [7:0] r;
    r = p;
    case (op)
      ALU_NZ:   begin r[7] = n; r[1] = z; end
      ALU_NZC:  begin r[7] = n; r[1] = z; r[0] = c; end
      ALU_NVZC: begin r[7] = n; r[6] = v; r[1] = z; r[0] = c; end
      BIT:      begin r[7] = d[7]; r[6] = d[6]; r[1] = z; end
      LOAD_BUS: r = d | 8'h30;
      SEC:      r[0] = 1'b1;
      CLC:      r[0] = 1'b0;
      SEI:      r[2] = 1'b1;
      CLI:      r[2] = 1'b0;
      SED:      r[3] = 1'b1;
      CLD:      r[3] = 1'b0;
      CLV:      r[6] = 1'b0;
      default:  r = p;
    endcase
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_p   <= 8'h24 | 8'h30;
      irq_h <= '1;
      nmi_h <= '1;
      m_nmi <= 1'b0;
    end else begin
      if (nmi_h[SYNC] && !nmi_h[SYNC-1]) m_nmi <= 1'b1;
      else if (sr.nmi_ack)               m_nmi <= 1'b0;
      irq_h <= {irq_h[SYNC-1:0], sr.irq_n};
      nmi_h <= {nmi_h[SYNC-1:0], sr.nmi_n};
      m_p   <= next_p(m_p, sr.flag_op, sr.alu_negative, sr.alu_overflow,
                      sr.alu_zero, sr.alu_carry, sr.data_in);
    end
  end

  always @(negedge clk) begin
    if ($time > 1) begin
      chk("m_p_out", sr.p_out, m_p);
      chk("m_p_push", sr.p_push, (m_p & 8'hEF) | {3'b000, sr.push_brk, 4'b0000});
      chk1("m_carry", sr.carry_flag, m_p[0]);
      chk1("m_decimal", sr.decimal_flag, DEC_EXP & m_p[3]);
      chk1("m_irq_pending", sr.irq_pending, ~irq_h[SYNC-1] & ~m_p[2]);
      chk1("m_nmi_pending", sr.nmi_pending, m_nmi);
    end
  end

  task automatic apply(input flag_op_t op, input logic n, input logic v, input logic z,
                       input logic c, input logic [7:0] d);
    sr.flag_op      = op;
    sr.alu_negative = n;
    sr.alu_overflow = v;
    sr.alu_zero     = z;
    sr.alu_carry    = c;
    sr.data_in      = d;
    @(posedge clk);
    #1;
    sr.flag_op = NOP;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    sr.flag_op      = NOP;
    sr.alu_negative = 1'b0;
    sr.alu_overflow = 1'b0;
    sr.alu_zero     = 1'b0;
    sr.alu_carry    = 1'b0;
    sr.data_in      = 8'h00;
    sr.push_brk     = 1'b1;
    sr.irq_n        = 1'b1;
    sr.nmi_n        = 1'b1;
    sr.nmi_ack      = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    chk("reset_p_out", sr.p_out, 8'h34);
    chk1("reset_irq", sr.irq_pending, 1'b0);
    chk1("reset_nmi", sr.nmi_pending, 1'b0);
    chk1("reset_decimal", sr.decimal_flag, 1'b0);

    apply(ALU_NVZC, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    chk("nvzc_p_out", sr.p_out, 8'h75);
    chk1("nvzc_carry", sr.carry_flag, 1'b1);
    apply(ALU_NZ, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    chk("nz_p_out", sr.p_out, 8'hF7);

    apply(LOAD_BUS, 1'b0, 1'b0, 1'b0, 1'b0, 8'hCF);
    chk("load_cf", sr.p_out, 8'hFF);
    apply(LOAD_BUS, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("load_00", sr.p_out, 8'h30);
    sr.push_brk = 1'b0;
    #1 chk("push_irq", sr.p_push, 8'h20);
    sr.push_brk = 1'b1;
    #1 chk("push_brk", sr.p_push, 8'h30);

    apply(SEI, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("sei_p_out", sr.p_out, 8'h34);
    sr.irq_n = 1'b0;
    idle(4);
    chk1("irq_masked", sr.irq_pending, 1'b0);
    apply(CLI, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("cli_p_out", sr.p_out, 8'h30);
    chk1("irq_after_cli", sr.irq_pending, 1'b1);
    apply(SEI, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk1("irq_after_sei", sr.irq_pending, 1'b0);
    sr.irq_n = 1'b1;
    idle(3);

    sr.nmi_n = 1'b0;
    idle(1);
    chk1("nmi_lat1", sr.nmi_pending, 1'b0);
    idle(1);
    chk1("nmi_lat2", sr.nmi_pending, 1'b0);
    idle(1);
    chk1("nmi_lat3", sr.nmi_pending, 1'b1);
    sr.nmi_ack = 1'b1;
    idle(1);
    sr.nmi_ack = 1'b0;
    chk1("nmi_acked", sr.nmi_pending, 1'b0);
    idle(4);
    chk1("nmi_no_retrigger", sr.nmi_pending, 1'b0);

    sr.nmi_n = 1'b1;
    idle(4);
    sr.nmi_n = 1'b0;
    idle(2);
    chk1("nmi_pre_coincide", sr.nmi_pending, 1'b0);
    sr.nmi_ack = 1'b1;
    idle(1);
    sr.nmi_ack = 1'b0;
    chk1("nmi_set_beats_ack", sr.nmi_pending, 1'b1);
    sr.nmi_ack = 1'b1;
    idle(1);
    sr.nmi_ack = 1'b0;
    chk1("nmi_cleared_held_low", sr.nmi_pending, 1'b0);
    sr.nmi_n = 1'b1;
    idle(3);

    apply(SED, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("sed_p_out", sr.p_out, 8'h3C);
    chk1("sed_decimal", sr.decimal_flag, DEC_EXP);
    apply(CLD, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("cld_p_out", sr.p_out, 8'h34);
    apply(SEC, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("sec_p_out", sr.p_out, 8'h35);
    apply(CLC, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("clc_p_out", sr.p_out, 8'h34);
    apply(BIT, 1'b0, 1'b0, 1'b1, 1'b1, 8'hC0);
    chk("bit_p_out", sr.p_out, 8'hF6);
    apply(CLV, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("clv_p_out", sr.p_out, 8'hB6);
    apply(flag_op_t'(4'd13), 1'b1, 1'b1, 1'b0, 1'b1, 8'hFF);
    chk("unlisted_hold", sr.p_out, 8'hB6);
    apply(ALU_NZC, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    chk("nzc_p_out", sr.p_out, 8'h35);

    sr.nmi_n = 1'b0;
    idle(3);
    chk1("nmi_before_reset", sr.nmi_pending, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_p_out", sr.p_out, 8'h34);
    chk1("midreset_nmi", sr.nmi_pending, 1'b0);
    idle(2);
    rst_n    = 1'b1;
    sr.nmi_n = 1'b1;
    idle(3);
    chk1("nmi_after_reset", sr.nmi_pending, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
